// File: rtl/mips_pkg.sv
// Shared widths and ALU-arbiter FSM state encoding for the MIPS core.
package mips_pkg;

  localparam int unsigned OPALU_W   = 2;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } arb_state_e;

endpackage

// File: rtl/ula_arbiter_rr.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the one not granted last.
module ula_arbiter_rr (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic last_grant_i,
  output logic gnt0_o,
  output logic gnt1_o
);

  always_comb begin
    gnt0_o = valid0_i & (~valid1_i | last_grant_i);
    gnt1_o = valid1_i & (~valid0_i | ~last_grant_i);
  end

endmodule

// File: rtl/ula_arbiter.sv
// Time-shares one ALU between two requesters: accept, hold operands for the ALU latency,
// capture the result and return it to the granted requester.
module ula_arbiter
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH       = DEF_WIDTH,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               req0_valid,
  input  logic               req1_valid,
  output logic               req0_ready,
  output logic               req1_ready,
  input  logic [OPALU_W-1:0] req0_opalu,
  input  logic [OPALU_W-1:0] req1_opalu,
  input  logic [FUNCT_W-1:0] req0_funct,
  input  logic [FUNCT_W-1:0] req1_funct,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp0_valid,
  output logic               rsp1_valid,
  input  logic               rsp0_ready,
  input  logic               rsp1_ready,
  output logic [WIDTH-1:0]   rsp_result,
  output logic [OPALU_W-1:0] alu_opalu,
  output logic [FUNCT_W-1:0] alu_funct,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_result,
  output logic               busy,
  output logic               grant_id
);

  localparam int unsigned CntW = (ALU_LATENCY < 1) ? 1 : $clog2(ALU_LATENCY + 1);

  arb_state_e         state_q;
  logic [CntW-1:0]    cnt_q;
  logic [OPALU_W-1:0] alu_opalu_q;
  logic [FUNCT_W-1:0] alu_funct_q;
  logic [WIDTH-1:0]   alu_a_q;
  logic [WIDTH-1:0]   alu_b_q;
  logic [WIDTH-1:0]   result_q;
  logic               rsp0_valid_q;
  logic               rsp1_valid_q;
  logic               busy_q;
  logic               grant_id_q;
  logic               last_grant_q;

  logic gnt0, gnt1;
  logic accept0, accept1;
  logic rsp_taken;

  ula_arbiter_rr u_rr (
    .valid0_i     (req0_valid),
    .valid1_i     (req1_valid),
    .last_grant_i (last_grant_q),
    .gnt0_o       (gnt0),
    .gnt1_o       (gnt1)
  );

  always_comb begin
    req0_ready = (state_q == StIdle) & gnt0;
    req1_ready = (state_q == StIdle) & gnt1;
    accept0    = req0_valid & req0_ready;
    accept1    = req1_valid & req1_ready;
    rsp_taken  = grant_id_q ? rsp1_ready : rsp0_ready;
  end

  // ALU drive registers double as the operand latches; they are zeroed outside EXEC.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      alu_opalu_q  <= '0;
      alu_funct_q  <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      result_q     <= '0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      grant_id_q   <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept0 || accept1) begin
            alu_opalu_q  <= accept1 ? req1_opalu : req0_opalu;
            alu_funct_q  <= accept1 ? req1_funct : req0_funct;
            alu_a_q      <= accept1 ? req1_a : req0_a;
            alu_b_q      <= accept1 ? req1_b : req0_b;
            grant_id_q   <= accept1;
            last_grant_q <= accept1;
            cnt_q        <= CntW'(ALU_LATENCY);
            busy_q       <= 1'b1;
            state_q      <= StExec;
          end
        end
        StExec: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CntW'(1);
          end else begin
            result_q     <= alu_result;
            alu_opalu_q  <= '0;
            alu_funct_q  <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            rsp0_valid_q <= ~grant_id_q;
            rsp1_valid_q <= grant_id_q;
            state_q      <= StResp;
          end
        end
        StResp: begin
          if (rsp_taken) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    alu_opalu  = alu_opalu_q;
    alu_funct  = alu_funct_q;
    alu_a      = alu_a_q;
    alu_b      = alu_b_q;
    rsp_result = result_q;
    rsp0_valid = rsp0_valid_q;
    rsp1_valid = rsp1_valid_q;
    busy       = busy_q;
    grant_id   = grant_id_q;
  end

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed bench for ula_arbiter at ALU latencies 1, 3 and 0.
module tb_ula_arbiter;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Shared request fields; each DUT has its own valid/ready so only one is exercised at a time.
  logic [1:0]  op0 = '0, op1 = '0;
  logic [5:0]  fn0 = '0, fn1 = '0;
  logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;

  function automatic logic [31:0] alu_f(input logic [5:0] fn, input logic [31:0] a,
                                        input logic [31:0] b);
    return (fn == 6'h22) ? a - b : a + b;
  endfunction

  // L = 1 instance
  logic u1_v0 = 0, u1_v1 = 0, u1_rr0 = 0, u1_rr1 = 0;
  logic u1_rd0, u1_rd1, u1_rv0, u1_rv1, u1_busy, u1_gid;
  logic [31:0] u1_res, u1_aa, u1_ab, u1_ares;
  logic [1:0]  u1_aop;
  logic [5:0]  u1_afn;
  always_ff @(posedge clk) u1_ares <= alu_f(u1_afn, u1_aa, u1_ab);

  ula_arbiter #(.WIDTH(32), .ALU_LATENCY(1)) u1 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(u1_v0), .req1_valid(u1_v1), .req0_ready(u1_rd0), .req1_ready(u1_rd1),
    .req0_opalu(op0), .req1_opalu(op1), .req0_funct(fn0), .req1_funct(fn1),
    .req0_a(a0), .req0_b(b0), .req1_a(a1), .req1_b(b1),
    .rsp0_valid(u1_rv0), .rsp1_valid(u1_rv1), .rsp0_ready(u1_rr0), .rsp1_ready(u1_rr1),
    .rsp_result(u1_res), .alu_opalu(u1_aop), .alu_funct(u1_afn), .alu_a(u1_aa), .alu_b(u1_ab),
    .alu_result(u1_ares), .busy(u1_busy), .grant_id(u1_gid)
  );

  // L = 3 instance
  logic u3_v0 = 0, u3_v1 = 0, u3_rr0 = 1, u3_rr1 = 0;
  logic u3_rd0, u3_rd1, u3_rv0, u3_rv1, u3_busy, u3_gid;
  logic [31:0] u3_res, u3_aa, u3_ab, u3_ares;
  logic [1:0]  u3_aop;
  logic [5:0]  u3_afn;
  always_ff @(posedge clk) u3_ares <= alu_f(u3_afn, u3_aa, u3_ab);

  ula_arbiter #(.WIDTH(32), .ALU_LATENCY(3)) u3 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(u3_v0), .req1_valid(u3_v1), .req0_ready(u3_rd0), .req1_ready(u3_rd1),
    .req0_opalu(op0), .req1_opalu(op1), .req0_funct(fn0), .req1_funct(fn1),
    .req0_a(a0), .req0_b(b0), .req1_a(a1), .req1_b(b1),
    .rsp0_valid(u3_rv0), .rsp1_valid(u3_rv1), .rsp0_ready(u3_rr0), .rsp1_ready(u3_rr1),
    .rsp_result(u3_res), .alu_opalu(u3_aop), .alu_funct(u3_afn), .alu_a(u3_aa), .alu_b(u3_ab),
    .alu_result(u3_ares), .busy(u3_busy), .grant_id(u3_gid)
  );

  // L = 0 instance with a combinational ALU model
  logic u0_v0 = 0, u0_v1 = 0, u0_rr0 = 1, u0_rr1 = 0;
  logic u0_rd0, u0_rd1, u0_rv0, u0_rv1, u0_busy, u0_gid;
  logic [31:0] u0_res, u0_aa, u0_ab, u0_ares;
  logic [1:0]  u0_aop;
  logic [5:0]  u0_afn;
  assign u0_ares = alu_f(u0_afn, u0_aa, u0_ab);

  ula_arbiter #(.WIDTH(32), .ALU_LATENCY(0)) u0 (
    .clk(clk), .reset_n(reset_n),
    .req0_valid(u0_v0), .req1_valid(u0_v1), .req0_ready(u0_rd0), .req1_ready(u0_rd1),
    .req0_opalu(op0), .req1_opalu(op1), .req0_funct(fn0), .req1_funct(fn1),
    .req0_a(a0), .req0_b(b0), .req1_a(a1), .req1_b(b1),
    .rsp0_valid(u0_rv0), .rsp1_valid(u0_rv1), .rsp0_ready(u0_rr0), .rsp1_ready(u0_rr1),
    .rsp_result(u0_res), .alu_opalu(u0_aop), .alu_funct(u0_afn), .alu_a(u0_aa), .alu_b(u0_ab),
    .alu_result(u0_ares), .busy(u0_busy), .grant_id(u0_gid)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    #1;
  endtask

  initial begin
    do_reset();

    // Reset state
    chk("rst_rd0", u1_rd0, 0);
    chk("rst_rd1", u1_rd1, 0);
    chk("rst_rv0", u1_rv0, 0);
    chk("rst_rv1", u1_rv1, 0);
    chk("rst_res", u1_res, 0);
    chk("rst_alu_a", u1_aa, 0);
    chk("rst_busy", u1_busy, 0);
    chk("rst_gid", u1_gid, 0);

    // Single request, L=1: 5 + 7
    op0 = 2'd2; fn0 = 6'h20; a0 = 32'd5; b0 = 32'd7; u1_v0 = 1;
    #1;
    chk("single_rd0_t0", u1_rd0, 1);
    chk("single_rd1_t0", u1_rd1, 0);
    tick(); u1_v0 = 0; #1;
    chk("single_alu_a_t1", u1_aa, 5);
    chk("single_alu_b_t1", u1_ab, 7);
    chk("single_alu_op_t1", u1_aop, 2);
    chk("single_alu_fn_t1", u1_afn, 32'h20);
    chk("single_busy_t1", u1_busy, 1);
    tick();
    chk("single_alu_a_t2", u1_aa, 5);
    chk("single_rv0_t2", u1_rv0, 0);
    tick();
    chk("single_rv0_t3", u1_rv0, 1);
    chk("single_rv1_t3", u1_rv1, 0);
    chk("single_res_t3", u1_res, 12);
    chk("single_alu_a_t3", u1_aa, 0);
    u1_rr0 = 1;
    tick();
    chk("single_busy_t4", u1_busy, 0);
    chk("single_rv0_t4", u1_rv0, 0);
    u1_rr0 = 0;

    // Simultaneous requests after reset: req0 first, then req1
    do_reset();
    a0 = 32'd1; b0 = 32'd2; fn0 = 6'h20;
    a1 = 32'd10; b1 = 32'd20; fn1 = 6'h22; op1 = 2'd2;
    u1_v0 = 1; u1_v1 = 1; u1_rr0 = 1; u1_rr1 = 1;
    #1;
    chk("tie_rd0", u1_rd0, 1);
    chk("tie_rd1", u1_rd1, 0);
    tick(); u1_v0 = 0; #1;
    chk("tie_gid_first", u1_gid, 0);
    chk("tie_rd1_busy", u1_rd1, 0);
    tick(); tick();
    chk("tie_rv0", u1_rv0, 1);
    chk("tie_res0", u1_res, 3);
    tick();
    chk("tie_rd1_next_idle", u1_rd1, 1);
    chk("tie_rd0_next_idle", u1_rd0, 0);
    tick(); u1_v1 = 0; #1;
    chk("tie_gid_second", u1_gid, 1);
    tick(); tick();
    chk("tie_rv1", u1_rv1, 1);
    chk("tie_rv0_low", u1_rv0, 0);
    chk("tie_res1", u1_res, 32'hFFFF_FFF6);
    tick();
    chk("tie_busy_end", u1_busy, 0);

    // Fairness: both held valid for six operations; last grant was 1, so 0 goes first
    u1_v0 = 1; u1_v1 = 1;
    #1;
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 10 && !(u1_rd0 || u1_rd1); c++) tick();
      chk("fair_gnt", {u1_rd1, u1_rd0}, (k % 2 == 0) ? 32'd1 : 32'd2);
      tick();
      for (int c = 0; c < 10 && !(u1_rv0 || u1_rv1); c++) tick();
      chk("fair_rsp", {u1_rv1, u1_rv0}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("fair_res", u1_res, (k % 2 == 0) ? 32'd3 : 32'hFFFF_FFF6);
      tick();
    end
    u1_v0 = 0; u1_v1 = 0; u1_rr0 = 0; u1_rr1 = 0;
    tick();
    chk("fair_idle", u1_busy, 0);

    // Response backpressure on requester 1 while requester 0 waits
    a1 = 32'd100; b1 = 32'd23; fn1 = 6'h20; u1_v1 = 1;
    #1;
    chk("bp_rd1", u1_rd1, 1);
    tick(); u1_v1 = 0; u1_v0 = 1; #1;
    tick(); tick();
    for (int c = 0; c < 10; c++) begin
      chk("bp_rv1_hold", u1_rv1, 1);
      chk("bp_res_hold", u1_res, 123);
      chk("bp_rd0_low", u1_rd0, 0);
      tick();
    end
    u1_rr1 = 1; #1;
    chk("bp_rv1_at_ready", u1_rv1, 1);
    tick();
    chk("bp_idle_busy", u1_busy, 0);
    chk("bp_idle_rv1", u1_rv1, 0);
    chk("bp_idle_rd0", u1_rd0, 1);
    u1_v0 = 0; u1_rr1 = 0;
    tick();

    // Reset mid-EXEC on the L=3 instance
    a0 = 32'd4; b0 = 32'd4; fn0 = 6'h20; u3_v0 = 1;
    #1;
    chk("l3_rd0", u3_rd0, 1);
    tick(); u3_v0 = 0; #1;
    tick();
    chk("l3_busy_exec", u3_busy, 1);
    chk("l3_alu_a_exec", u3_aa, 4);
    reset_n = 1'b0;
    #1;
    chk("l3_rst_busy", u3_busy, 0);
    chk("l3_rst_alu_a", u3_aa, 0);
    chk("l3_rst_alu_b", u3_ab, 0);
    chk("l3_rst_rv0", u3_rv0, 0);
    chk("l3_rst_rd0", u3_rd0, 0);
    chk("l3_rst_res", u3_res, 0);
    chk("l3_rst_gid", u3_gid, 0);
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("l3_no_rsp", u3_rv0, 0);
    end

    // L=0: 0xFFFFFFFF + 1 wraps to 0, response at t+2
    a0 = 32'hFFFF_FFFF; b0 = 32'd1; fn0 = 6'h20; op0 = 2'd2; u0_v0 = 1;
    #1;
    chk("l0_rd0", u0_rd0, 1);
    tick(); u0_v0 = 0; #1;
    chk("l0_rv0_t1", u0_rv0, 0);
    chk("l0_alu_a_t1", u0_aa, 32'hFFFF_FFFF);
    chk("l0_alu_b_t1", u0_ab, 1);
    tick();
    chk("l0_rv0_t2", u0_rv0, 1);
    chk("l0_res_t2", u0_res, 32'h0000_0000);
    tick();
    chk("l0_busy_end", u0_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ula_arbiter.md
# ula_arbiter

Two-requester arbiter and sequencer that time-shares the single ALU datapath (ULAControl + ULA pair) of the MIPS core. It accepts operation requests (OpALU, funct, a, b) over valid/ready handshakes, grants one at a time with round-robin fairness, and holds the ALU inputs stable for the ALU's fixed latency. It then captures the result and returns it to the granted requester over a valid/ready response channel. It sits between the core's issue logic (e.g. execute stage and address-calculation unit) and the ALU instance.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- ALU_LATENCY, 1, cycles from stable ALU inputs to valid alu_result (0 = combinational ALU)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request pending
- req0_ready / req1_ready  out  1  request accepted this cycle when high with valid
- req0_opalu / req1_opalu  in  2  OpALU code
- req0_funct / req1_funct  in  6  funct field
- req0_a, req0_b / req1_a, req1_b  in  WIDTH  operands
- rsp0_valid / rsp1_valid  out  1  result available
- rsp0_ready / rsp1_ready  in  1  requester takes result
- rsp_result  out  WIDTH  result, shared by both response channels
- alu_opalu  out  2, alu_funct  out  6, alu_a / alu_b  out  WIDTH  drive the ALU
- alu_result  in  WIDTH  ALU output
- busy  out  1  high in any state but IDLE
- grant_id  out  1  index of current or last granted requester

## Operation
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - reqN_ready is high only for the requester selected by arbitration, and only when that requester is valid. At most one ready is high.
  - Accept = valid & ready. On accept, latch opalu/funct/a/b, set grant_id, load cnt = ALU_LATENCY, update last_grant, go to EXEC.
- Arbitration:
  - If only one requester is valid, it wins.
  - If both are valid, the winner is the requester != last_grant.
  - last_grant resets to 1, so requester 0 wins the first tie.
- EXEC:
  - alu_* outputs equal the latched values, stable every cycle.
  - If cnt != 0, decrement.
  - If cnt == 0, capture alu_result into the result register and go to RESP.
- RESP:
  - rsp<grant_id>_valid is high; the other rsp valid is low. rsp_result equals the captured value.
  - Hold until rsp<grant_id>_ready is high, then go to IDLE. There is no timeout.
- Outside EXEC, alu_opalu/funct/a/b drive 0.
- funct and opalu are passed through undecoded; illegal codes are not checked.
- Requests are never dropped: an unselected valid requester waits, and it must hold its fields stable until accepted.

## Timing
- Reset values:
  - All reqN_ready = 0, rspN_valid = 0, rsp_result = 0.
  - alu_* = 0, busy = 0, grant_id = 0, last_grant = 1.
  - State = IDLE, cnt = 0.
- Cycle numbering:
  - Accept in cycle t.
  - alu_* valid cycles t+1 .. t+1+L, where L = ALU_LATENCY.
  - Result sampled at the end of cycle t+1+L.
  - rsp_valid first high in cycle t+2+L.
- With rsp_ready held high, the next accept is possible at t+3+L. Minimum issue interval is L+3 cycles.
- No accept occurs in the same cycle as a response handshake.
- Asynchronous reset mid-EXEC or mid-RESP aborts immediately: the result is discarded, no response is issued, and all outputs take reset values.
- While busy, new requests see ready = 0. Arbitration is evaluated only in IDLE.

## Structure
- Shared package mips_pkg holds:
  - OPALU_W = 2, FUNCT_W = 6, and the default WIDTH = 32.
  - The state typedef (IDLE, EXEC, RESP).
- Sub-module ula_arbiter_rr: a 2-way round-robin grant from (valid0, valid1, last_grant) producing (gnt0, gnt1). It is purely combinational.
- The top module holds the FSM, latency counter, operand registers and result register.

## Test plan
- Single request, L=1: req0 with opalu=2, funct=0x20, a=5, b=7 at t=0; ALU model returns 12.
  - Required: req0_ready at t=0, alu_a=5 in t=1..2, rsp0_valid at t=3 with rsp_result=12.
- Simultaneous requests after reset: both valid at t=0.
  - Required: req0 is granted first. req1 is granted at the next IDLE. grant_id sequence is 0, 1.
- Fairness: both valid continuously for 6 operations.
  - Required: grants alternate 0, 1, 0, 1, 0, 1, and no request is lost.
- Response backpressure: rsp1_ready held low for 10 cycles.
  - Required: rsp1_valid stays high, rsp_result is stable, req0_ready stays 0 throughout, and IDLE is resumed one cycle after rsp1_ready rises.
- Reset mid-operation: assert reset_n=0 during EXEC with L=3.
  - Required: all outputs return to reset values immediately. After release, no rsp_valid appears without a new request.
- L=0 build: single request with a=0xFFFFFFFF, b=1.
  - Required: rsp_valid at t+2 carrying the ALU model's 32-bit wrapped sum, 0x00000000.
